alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Round-robin scheduler that shares one ALU datapath instance between NREQ requesters.
- Accepts one operation at a time over a valid/ready request handshake and drives the ALU control and operand inputs, pulsing CE for exactly one cycle.
- Captures RES and flags one cycle later and returns them, tagged with the requester ID, over a valid/ready response handshake.
- Sits between the processing clients and the ALU in the compute subsystem.

Parameters:
- WIDTH, 8, operand width; must match the ALU instance.
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ), requester-ID width (localparam).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset; also wired to the ALU RST.
- REQ_VALID  in  NREQ  per-requester request valid.
- REQ_READY  out  NREQ  one-hot accept pulse.
- REQ_MODE  in  NREQ  per-requester MODE.
- REQ_CMD  in  4*NREQ  per-requester CMD, slice i = [4i+3:4i].
- REQ_OPA  in  WIDTH*NREQ  per-requester OPA.
- REQ_OPB  in  WIDTH*NREQ  per-requester OPB.
- REQ_CIN  in  NREQ  per-requester CIN.
- REQ_INP_VALID  in  2*NREQ  per-requester INP_VALID.
- ALU_CE  out  1  ALU clock enable.
- ALU_MODE  out  1  to ALU MODE.
- ALU_CMD  out  4  to ALU CMD.
- ALU_OPA  out  WIDTH  to ALU OPA.
- ALU_OPB  out  WIDTH  to ALU OPB.
- ALU_CIN  out  1  to ALU CIN.
- ALU_INP_VALID  out  2  to ALU INP_VALID.
- ALU_RES  in  2*WIDTH+1  from ALU RES.
- ALU_FLAGS  in  6  {ERR,OFLOW,COUT,G,L,E} from ALU.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response accept.
- RSP_ID  out  IDW  index of the served requester.
- RSP_RES  out  2*WIDTH+1  captured result.
- RSP_FLAGS  out  6  captured {ERR,OFLOW,COUT,G,L,E}.

Behaviour:
- Single clock domain; all state updates on the rising CLK edge when RST=1 (synchronous, active-high).
- Reset values:
  - FSM = IDLE; RR pointer = NREQ-1, so requester 0 wins first.
  - ALU_CE=0; all ALU_* operand and control regs = 0.
  - REQ_READY=0; RSP_VALID=0; RSP_ID=0; RSP_RES=0; RSP_FLAGS=0.
- FSM states: IDLE -> ISSUE -> CAPT -> RESP.
- IDLE:
  - If |REQ_VALID, pick the first valid index searching upward from ptr+1 (mod NREQ).
  - Assert REQ_READY[g] combinationally for this cycle only.
  - Register that requester's fields into ALU_* and its index into the grant reg; set ptr=g; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: ALU_CE=1 for this one cycle; the ALU registers its result at the end of the cycle; go to CAPT.
- CAPT:
  - ALU_CE=0.
  - RSP_RES<=ALU_RES; RSP_FLAGS<=ALU_FLAGS; RSP_ID<=grant; RSP_VALID<=1; go to RESP.
- RESP:
  - Hold RSP_* stable while RSP_VALID=1 and RSP_READY=0.
  - On RSP_READY=1: RSP_VALID<=0; go to IDLE.
- ALU_* operand and control outputs hold their registered values from accept until the next accept, because the ALU precomputes combinationally from MODE/CMD.
- Latency: accept edge to RSP_VALID=1 is 3 cycles. Minimum issue interval is 4 cycles.
- REQ_READY is never asserted outside IDLE, so requesters hold their request until accepted.
- Simultaneous valids: strict rotation, so no requester is starved and each waits at most NREQ-1 grants.
- The scheduler passes CMD and INP_VALID through without interpretation; the ALU flags ERR itself (e.g. INP_VALID=00).
- RST in any state: FSM returns to IDLE next edge, RSP_VALID drops, and the in-flight operation is discarded with no response.

Optional Feature:
- Macro: ALU_SCHED_STATS_EN.
- Defined:
  - Adds output STAT_GRANT_CNT (16*NREQ): per-requester grant counters, incremented on accept.
  - Adds output STAT_ERR_CNT (16): incremented in CAPT when ALU_FLAGS[5]=1.
  - All counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - CMD encodings;
  - flag bit indices (ERR=5, OFLOW=4, COUT=3, G=2, L=1, E=0);
  - FSM state encoding for IDLE, ISSUE, CAPT, RESP.
- Sub-module rr_arbiter (parameter NREQ): inputs req and ptr, outputs one-hot grant and grant index; purely combinational.
- The FSM and datapath regs stay in alu_sched.

Test Plan:
- Req0 ADD (MODE=1, CMD=ADD, OPA=8'hFF, OPB=8'h01, INP_VALID=11): RSP_VALID 3 cycles after accept; RSP_ID=0; RSP_RES=9'h100; COUT=1.
- REQ_VALID=2'b11 held after reset: grants go 0,1,0,1; each REQ_READY is a single-cycle pulse.
- RSP_READY=0 for 5 cycles in RESP: RSP_* stable, no REQ_READY asserted; first accept occurs in the cycle after the RSP_READY=1 handshake.
- Req1 with INP_VALID=00: RSP_FLAGS[5]=1, RSP_RES=0, RSP_ID=1.
- RST=1 during ISSUE: next cycle FSM in IDLE, RSP_VALID=0, no response ever emitted; subsequent request served normally.
- With ALU_SCHED_STATS_EN: 3 grants to req0 and 1 erroring op to req1 give STAT_GRANT_CNT={16'd1,16'd3} and STAT_ERR_CNT=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU scheduler slice.
//   - ALU command encodings (arithmetic set when MODE=1, logical set when MODE=0)
//   - bit positions of the ALU flag vector {ERR,OFLOW,COUT,G,L,E}
//   - scheduler FSM state encoding
//   - saturating 16-bit increment used by the optional statistics counters
package alu_pkg;

    // Arithmetic commands (MODE = 1)
    localparam logic [3:0] CMD_ADD     = 4'd0;
    localparam logic [3:0] CMD_SUB     = 4'd1;
    localparam logic [3:0] CMD_ADD_CIN = 4'd2;
    localparam logic [3:0] CMD_SUB_CIN = 4'd3;
    localparam logic [3:0] CMD_INC_A   = 4'd4;
    localparam logic [3:0] CMD_DEC_A   = 4'd5;
    localparam logic [3:0] CMD_CMP     = 4'd8;

    // Logical commands (MODE = 0)
    localparam logic [3:0] CMD_AND     = 4'd0;
    localparam logic [3:0] CMD_NAND    = 4'd1;
    localparam logic [3:0] CMD_OR      = 4'd2;
    localparam logic [3:0] CMD_NOR     = 4'd3;
    localparam logic [3:0] CMD_XOR     = 4'd4;

    // Flag vector bit indices
    localparam int unsigned FLAG_ERR   = 5;
    localparam int unsigned FLAG_OFLOW = 4;
    localparam int unsigned FLAG_COUT  = 3;
    localparam int unsigned FLAG_G     = 2;
    localparam int unsigned FLAG_L     = 1;
    localparam int unsigned FLAG_E     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        logic [15:0] res;
        if (val == 16'hFFFF) begin
            res = 16'hFFFF;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
// The search starts at ptr+1 (mod NREQ) and returns the first asserted request.
// Ports:
//   req       in  NREQ  request vector
//   ptr       in  IDW   index of the most recent winner
//   grant     out NREQ  one-hot grant (all zero when no request)
//   grant_idx out IDW   index of the granted requester (0 when no request)
module rr_arbiter #(
    parameter int  NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    // Rotating priority search; 'found_s' masks every hit after the first
    always_comb begin
        logic found_s;
        logic hit_s;
        int   idx_s;
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        idx_s     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx_s        = (int'(ptr) + i) % NREQ;
            hit_s        = req[idx_s] & ~found_s;
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx    = hit_s ? idx_s[IDW-1:0] : grant_idx;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one ALU between NREQ requesters.
// One operation is accepted at a time (IDLE), issued with a single-cycle ALU_CE
// (ISSUE), its registered result captured (CAPT) and returned tagged with the
// requester index until the consumer accepts it (RESP).
// Optional build macro: ALU_SCHED_STATS_EN adds per-requester grant counters
// and an ALU error counter (16-bit, saturating).
// Ports:
//   CLK, RST                 clock, synchronous active-high reset (also feeds the ALU)
//   REQ_VALID/REQ_READY      per-requester request handshake (READY is a one-hot pulse)
//   REQ_MODE/CMD/OPA/OPB/CIN/INP_VALID  per-requester operation fields, slice i per requester
//   ALU_CE, ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_CIN, ALU_INP_VALID  to the ALU
//   ALU_RES, ALU_FLAGS       from the ALU
//   RSP_VALID/RSP_READY      response handshake; RSP_ID, RSP_RES, RSP_FLAGS payload
//   STAT_GRANT_CNT, STAT_ERR_CNT  statistics (only with ALU_SCHED_STATS_EN)
module alu_sched
    import alu_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  NREQ  = 2,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ_VALID,
    output logic [NREQ-1:0]       REQ_READY,
    input  logic [NREQ-1:0]       REQ_MODE,
    input  logic [4*NREQ-1:0]     REQ_CMD,
    input  logic [WIDTH*NREQ-1:0] REQ_OPA,
    input  logic [WIDTH*NREQ-1:0] REQ_OPB,
    input  logic [NREQ-1:0]       REQ_CIN,
    input  logic [2*NREQ-1:0]     REQ_INP_VALID,
    output logic                  ALU_CE,
    output logic                  ALU_MODE,
    output logic [3:0]            ALU_CMD,
    output logic [WIDTH-1:0]      ALU_OPA,
    output logic [WIDTH-1:0]      ALU_OPB,
    output logic                  ALU_CIN,
    output logic [1:0]            ALU_INP_VALID,
    input  logic [2*WIDTH:0]      ALU_RES,
    input  logic [5:0]            ALU_FLAGS,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [IDW-1:0]        RSP_ID,
    output logic [2*WIDTH:0]      RSP_RES,
    output logic [5:0]            RSP_FLAGS
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [16*NREQ-1:0]    STAT_GRANT_CNT,
    output logic [15:0]           STAT_ERR_CNT
`endif
);

    sched_state_e          state_r;
    sched_state_e          state_nxt_s;
    logic [IDW-1:0]        ptr_r;
    logic [IDW-1:0]        grant_r;
    logic [NREQ-1:0]       gnt_oh_s;
    logic [IDW-1:0]        gnt_idx_s;
    logic                  accept_s;

    logic                  sel_mode_s;
    logic [3:0]            sel_cmd_s;
    logic [WIDTH-1:0]      sel_opa_s;
    logic [WIDTH-1:0]      sel_opb_s;
    logic                  sel_cin_s;
    logic [1:0]            sel_iv_s;

    logic                  alu_ce_r;
    logic                  alu_mode_r;
    logic [3:0]            alu_cmd_r;
    logic [WIDTH-1:0]      alu_opa_r;
    logic [WIDTH-1:0]      alu_opb_r;
    logic                  alu_cin_r;
    logic [1:0]            alu_iv_r;

    logic                  rsp_valid_r;
    logic [IDW-1:0]        rsp_id_r;
    logic [2*WIDTH:0]      rsp_res_r;
    logic [5:0]            rsp_flags_r;

    rr_arbiter #(
        .NREQ      (NREQ)
    ) u_arb (
        .req       (REQ_VALID),
        .ptr       (ptr_r),
        .grant     (gnt_oh_s),
        .grant_idx (gnt_idx_s)
    );

    assign accept_s = (state_r == ST_IDLE) && (|REQ_VALID);

    // Next-state logic of the accept/issue/capture/respond sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|REQ_VALID) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_CAPT;
            ST_CAPT:  state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (RSP_READY) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Accept pulse: only in IDLE, so a requester keeps its request until served
    always_comb begin
        REQ_READY = '0;
        if (state_r == ST_IDLE) begin
            REQ_READY = gnt_oh_s;
        end else begin
            REQ_READY = '0;
        end
    end

    // One-hot AND-OR select of the winning requester's operation fields
    always_comb begin
        sel_mode_s = 1'b0;
        sel_cmd_s  = 4'd0;
        sel_opa_s  = '0;
        sel_opb_s  = '0;
        sel_cin_s  = 1'b0;
        sel_iv_s   = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            sel_mode_s = sel_mode_s | (REQ_MODE[i] & gnt_oh_s[i]);
            sel_cmd_s  = sel_cmd_s  | (REQ_CMD[4*i +: 4] & {4{gnt_oh_s[i]}});
            sel_opa_s  = sel_opa_s  | (REQ_OPA[WIDTH*i +: WIDTH] & {WIDTH{gnt_oh_s[i]}});
            sel_opb_s  = sel_opb_s  | (REQ_OPB[WIDTH*i +: WIDTH] & {WIDTH{gnt_oh_s[i]}});
            sel_cin_s  = sel_cin_s  | (REQ_CIN[i] & gnt_oh_s[i]);
            sel_iv_s   = sel_iv_s   | (REQ_INP_VALID[2*i +: 2] & {2{gnt_oh_s[i]}});
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand/control registers, grant tracking and response capture.
    // ALU_* fields are held until the next accept because the ALU decodes
    // MODE/CMD combinationally ahead of the CE cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_r       <= IDW'(NREQ - 1);
            grant_r     <= '0;
            alu_ce_r    <= 1'b0;
            alu_mode_r  <= 1'b0;
            alu_cmd_r   <= 4'd0;
            alu_opa_r   <= '0;
            alu_opb_r   <= '0;
            alu_cin_r   <= 1'b0;
            alu_iv_r    <= 2'd0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_res_r   <= '0;
            rsp_flags_r <= 6'd0;
        end else begin
            alu_ce_r <= (state_nxt_s == ST_ISSUE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        alu_mode_r <= sel_mode_s;
                        alu_cmd_r  <= sel_cmd_s;
                        alu_opa_r  <= sel_opa_s;
                        alu_opb_r  <= sel_opb_s;
                        alu_cin_r  <= sel_cin_s;
                        alu_iv_r   <= sel_iv_s;
                        grant_r    <= gnt_idx_s;
                        ptr_r      <= gnt_idx_s;
                    end
                end
                ST_CAPT: begin
                    rsp_res_r   <= ALU_RES;
                    rsp_flags_r <= ALU_FLAGS;
                    rsp_id_r    <= grant_r;
                    rsp_valid_r <= 1'b1;
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= rsp_valid_r;
                end
            endcase
        end
    end

    assign ALU_CE        = alu_ce_r;
    assign ALU_MODE      = alu_mode_r;
    assign ALU_CMD       = alu_cmd_r;
    assign ALU_OPA       = alu_opa_r;
    assign ALU_OPB       = alu_opb_r;
    assign ALU_CIN       = alu_cin_r;
    assign ALU_INP_VALID = alu_iv_r;
    assign RSP_VALID     = rsp_valid_r;
    assign RSP_ID        = rsp_id_r;
    assign RSP_RES       = rsp_res_r;
    assign RSP_FLAGS     = rsp_flags_r;

`ifdef ALU_SCHED_STATS_EN
    logic [NREQ-1:0][15:0] grant_cnt_r;
    logic [15:0]           err_cnt_r;

    // Saturating grant counters (on accept) and ALU error counter (on capture)
    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_cnt_r <= '0;
            err_cnt_r   <= 16'd0;
        end else begin
            if (accept_s) begin
                grant_cnt_r[gnt_idx_s] <= sat_inc16(grant_cnt_r[gnt_idx_s]);
            end
            if ((state_r == ST_CAPT) && ALU_FLAGS[FLAG_ERR]) begin
                err_cnt_r <= sat_inc16(err_cnt_r);
            end
        end
    end

    assign STAT_GRANT_CNT = grant_cnt_r;
    assign STAT_ERR_CNT   = err_cnt_r;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: self-checking bench for alu_sched with a small behavioural ALU.
// Expected responses are pushed to a scoreboard queue when an accept is seen
// and popped/compared at the response handshake. Stats checks are compiled
// only when ALU_SCHED_STATS_EN is defined.
`timescale 1ns/1ps
module tb_alu_sched;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int NREQ  = 2;
    localparam int IDW   = 1;
    localparam int RW    = 2*WIDTH + 1;

    logic                  CLK;
    logic                  RST;
    logic [NREQ-1:0]       REQ_VALID;
    logic [NREQ-1:0]       REQ_READY;
    logic [NREQ-1:0]       REQ_MODE;
    logic [4*NREQ-1:0]     REQ_CMD;
    logic [WIDTH*NREQ-1:0] REQ_OPA;
    logic [WIDTH*NREQ-1:0] REQ_OPB;
    logic [NREQ-1:0]       REQ_CIN;
    logic [2*NREQ-1:0]     REQ_INP_VALID;
    logic                  ALU_CE;
    logic                  ALU_MODE;
    logic [3:0]            ALU_CMD;
    logic [WIDTH-1:0]      ALU_OPA;
    logic [WIDTH-1:0]      ALU_OPB;
    logic                  ALU_CIN;
    logic [1:0]            ALU_INP_VALID;
    logic [RW-1:0]         ALU_RES;
    logic [5:0]            ALU_FLAGS;
    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic [IDW-1:0]        RSP_ID;
    logic [RW-1:0]         RSP_RES;
    logic [5:0]            RSP_FLAGS;
`ifdef ALU_SCHED_STATS_EN
    logic [16*NREQ-1:0]    STAT_GRANT_CNT;
    logic [15:0]           STAT_ERR_CNT;
`endif

    logic             r_mode [NREQ];
    logic [3:0]       r_cmd  [NREQ];
    logic [WIDTH-1:0] r_opa  [NREQ];
    logic [WIDTH-1:0] r_opb  [NREQ];
    logic             r_cin  [NREQ];
    logic [1:0]       r_iv   [NREQ];

    typedef struct {
        logic [IDW-1:0] id;
        logic [RW-1:0]  res;
        logic [5:0]     flags;
        int             acc_cyc;
    } exp_t;

    exp_t sb_q [$];
    int   gseq [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_acc_cyc = -10;
    int   last_hs_cyc  = -10;
    int   n_rsp = 0;
    logic [IDW-1:0] last_id;
    logic [RW-1:0]  last_res;
    logic [5:0]     last_flags;
    logic [NREQ-1:0] prev_ready = '0;
    logic            prev_rsp_valid = 1'b0;
    logic            prev_rsp_ready = 1'b0;
    logic [IDW-1:0]  prev_id;
    logic [RW-1:0]   prev_res;
    logic [5:0]      prev_flags;

    alu_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .REQ_VALID     (REQ_VALID),
        .REQ_READY     (REQ_READY),
        .REQ_MODE      (REQ_MODE),
        .REQ_CMD       (REQ_CMD),
        .REQ_OPA       (REQ_OPA),
        .REQ_OPB       (REQ_OPB),
        .REQ_CIN       (REQ_CIN),
        .REQ_INP_VALID (REQ_INP_VALID),
        .ALU_CE        (ALU_CE),
        .ALU_MODE      (ALU_MODE),
        .ALU_CMD       (ALU_CMD),
        .ALU_OPA       (ALU_OPA),
        .ALU_OPB       (ALU_OPB),
        .ALU_CIN       (ALU_CIN),
        .ALU_INP_VALID (ALU_INP_VALID),
        .ALU_RES       (ALU_RES),
        .ALU_FLAGS     (ALU_FLAGS),
        .RSP_VALID     (RSP_VALID),
        .RSP_READY     (RSP_READY),
        .RSP_ID        (RSP_ID),
        .RSP_RES       (RSP_RES),
        .RSP_FLAGS     (RSP_FLAGS)
`ifdef ALU_SCHED_STATS_EN
        ,
        .STAT_GRANT_CNT(STAT_GRANT_CNT),
        .STAT_ERR_CNT  (STAT_ERR_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Pack per-requester fields onto the flat request buses
    always_comb begin
        REQ_MODE      = '0;
        REQ_CMD       = '0;
        REQ_OPA       = '0;
        REQ_OPB       = '0;
        REQ_CIN       = '0;
        REQ_INP_VALID = '0;
        for (int i = 0; i < NREQ; i++) begin
            REQ_MODE[i]               = r_mode[i];
            REQ_CMD[4*i +: 4]         = r_cmd[i];
            REQ_OPA[WIDTH*i +: WIDTH] = r_opa[i];
            REQ_OPB[WIDTH*i +: WIDTH] = r_opb[i];
            REQ_CIN[i]                = r_cin[i];
            REQ_INP_VALID[2*i +: 2]   = r_iv[i];
        end
    end

    // Reference ALU behaviour: returns {RES, FLAGS}
    function automatic logic [RW+5:0] ref_alu(input logic m, input logic [3:0] c,
                                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic ci, input logic [1:0] iv);
        logic [RW-1:0] r;
        logic [5:0]    f;
        r = '0;
        f = 6'd0;
        if (iv != 2'b11) begin
            f[FLAG_ERR] = 1'b1;
        end else if (m) begin
            case (c)
                CMD_ADD:     r = RW'({1'b0, a} + {1'b0, b});
                CMD_SUB:     r = RW'({1'b0, a} - {1'b0, b});
                CMD_ADD_CIN: r = RW'({1'b0, a} + {1'b0, b} + {8'd0, ci});
                CMD_CMP: begin
                    f[FLAG_G] = (a > b);
                    f[FLAG_L] = (a < b);
                    f[FLAG_E] = (a == b);
                end
                default:     f[FLAG_ERR] = 1'b1;
            endcase
            f[FLAG_COUT] = r[WIDTH];
        end else begin
            case (c)
                CMD_AND: r = RW'(a & b);
                CMD_OR:  r = RW'(a | b);
                CMD_XOR: r = RW'(a ^ b);
                default: f[FLAG_ERR] = 1'b1;
            endcase
        end
        return {r, f};
    endfunction

    // Behavioural ALU: registers its result on the CE cycle
    always @(posedge CLK) begin
        if (RST) begin
            ALU_RES   <= '0;
            ALU_FLAGS <= 6'd0;
        end else if (ALU_CE) begin
            {ALU_RES, ALU_FLAGS} <= ref_alu(ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_CIN, ALU_INP_VALID);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor on the falling edge: scoreboard push/pop and protocol checks
    always @(negedge CLK) begin
        if (RST) begin
            sb_q.delete();
            prev_ready     <= '0;
            prev_rsp_valid <= 1'b0;
            prev_rsp_ready <= 1'b0;
        end else begin
            if (REQ_READY != '0) begin
                exp_t e;
                int   g;
                logic [RW+5:0] rf;
                g = (REQ_READY[1]) ? 1 : 0;
                check_eq("ready_onehot", 32'($onehot(REQ_READY)), 32'd1);
                check_eq("ready_pulse", 32'(prev_ready), 32'd0);
                check_eq("ready_while_rsp", 32'(RSP_VALID), 32'd0);
                check_eq("ready_has_valid", 32'(REQ_READY & ~REQ_VALID), 32'd0);
                rf        = ref_alu(r_mode[g], r_cmd[g], r_opa[g], r_opb[g], r_cin[g], r_iv[g]);
                e.id      = g[IDW-1:0];
                e.res     = rf[RW+5:6];
                e.flags   = rf[5:0];
                e.acc_cyc = cyc;
                sb_q.push_back(e);
                gseq.push_back(g);
                last_acc_cyc = cyc;
            end
            if (RSP_VALID && !prev_rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_rsp", 32'(sb_q.size()), 32'd1);
                end else begin
                    check_eq("latency", 32'(cyc - sb_q[0].acc_cyc), 32'd3);
                end
            end
            if (RSP_VALID && prev_rsp_valid && !prev_rsp_ready) begin
                check_eq("hold_id", 32'(RSP_ID), 32'(prev_id));
                check_eq("hold_res", 32'(RSP_RES), 32'(prev_res));
                check_eq("hold_flags", 32'(RSP_FLAGS), 32'(prev_flags));
            end
            if (RSP_VALID && RSP_READY && (sb_q.size() > 0)) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("rsp_id", 32'(RSP_ID), 32'(e.id));
                check_eq("rsp_res", 32'(RSP_RES), 32'(e.res));
                check_eq("rsp_flags", 32'(RSP_FLAGS), 32'(e.flags));
                last_id     = RSP_ID;
                last_res    = RSP_RES;
                last_flags  = RSP_FLAGS;
                last_hs_cyc = cyc;
                n_rsp++;
            end
            prev_ready     <= REQ_READY;
            prev_rsp_valid <= RSP_VALID;
            prev_rsp_ready <= RSP_READY;
            prev_id        <= RSP_ID;
            prev_res       <= RSP_RES;
            prev_flags     <= RSP_FLAGS;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_req(input int i, input logic m, input logic [3:0] c,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic ci, input logic [1:0] iv);
        r_mode[i] = m;
        r_cmd[i]  = c;
        r_opa[i]  = a;
        r_opb[i]  = b;
        r_cin[i]  = ci;
        r_iv[i]   = iv;
    endtask

    task automatic wait_accept(input string tag, input int budget);
        int n0;
        int k;
        n0 = gseq.size();
        k  = 0;
        while ((gseq.size() == n0) && (k < budget)) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(gseq.size()), 32'(n0 + 1));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while (((sb_q.size() != 0) || RSP_VALID) && (k < budget)) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int n_rsp0;
        RST       = 1'b1;
        REQ_VALID = '0;
        RSP_READY = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00);
        repeat (3) tick();

        // Reset state
        check_eq("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        check_eq("rst_rsp_id", 32'(RSP_ID), 32'd0);
        check_eq("rst_rsp_res", 32'(RSP_RES), 32'd0);
        check_eq("rst_rsp_flags", 32'(RSP_FLAGS), 32'd0);
        check_eq("rst_alu_ce", 32'(ALU_CE), 32'd0);
        check_eq("rst_alu_ops", 32'({ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_CIN, ALU_INP_VALID}), 32'd0);
        check_eq("rst_req_ready", 32'(REQ_READY), 32'd0);
        RST = 1'b0;
        tick();

        // Req0 ADD FF+01
        set_req(0, 1'b1, CMD_ADD, 8'hFF, 8'h01, 1'b0, 2'b11);
        REQ_VALID = 2'b01;
        wait_accept("acc_add", 20);
        REQ_VALID = 2'b00;
        wait_drain("drain_add", 20);
        check_eq("add_id", 32'(last_id), 32'd0);
        check_eq("add_res", 32'(last_res), 32'h100);
        check_eq("add_cout", 32'(last_flags[FLAG_COUT]), 32'd1);
        check_eq("add_err", 32'(last_flags[FLAG_ERR]), 32'd0);

        // Rotation with both requests held from reset
        RST = 1'b1;
        set_req(1, 1'b1, CMD_SUB, 8'h10, 8'h03, 1'b0, 2'b11);
        REQ_VALID = 2'b11;
        tick();
        gseq.delete();
        RST = 1'b0;
        for (int k = 0; k < 4; k++) wait_accept("acc_rot", 20);
        REQ_VALID = 2'b00;
        wait_drain("drain_rot", 20);
        for (int k = 0; k < 4; k++) begin
            if (k < gseq.size()) check_eq("rot_order", 32'(gseq[k]), 32'(k % 2));
        end
        check_eq("sub_res", 32'(last_res), 32'h0000D);

        // Response back-pressure with a competing request pending
        set_req(0, 1'b0, CMD_AND, 8'hF0, 8'h3C, 1'b0, 2'b11);
        REQ_VALID = 2'b01;
        RSP_READY = 1'b0;
        wait_accept("acc_bp", 20);
        set_req(1, 1'b0, CMD_XOR, 8'hA5, 8'h0F, 1'b0, 2'b11);
        REQ_VALID = 2'b10;
        begin
            int k;
            k = 0;
            while (!RSP_VALID && (k < 10)) begin tick(); k++; end
        end
        check_eq("bp_valid", 32'(RSP_VALID), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("bp_no_ready", 32'(REQ_READY), 32'd0);
            check_eq("bp_still_valid", 32'(RSP_VALID), 32'd1);
        end
        check_eq("bp_and_res", 32'(RSP_RES), 32'h30);
        RSP_READY = 1'b1;
        wait_accept("acc_after_bp", 10);
        REQ_VALID = 2'b00;
        check_eq("acc_after_hs", 32'(last_acc_cyc), 32'(last_hs_cyc + 1));
        wait_drain("drain_bp", 20);
        check_eq("xor_res", 32'(last_res), 32'hAA);
        check_eq("xor_id", 32'(last_id), 32'd1);

        // Req1 with no valid inputs: ALU reports ERR
        set_req(1, 1'b1, CMD_ADD, 8'h12, 8'h34, 1'b0, 2'b00);
        REQ_VALID = 2'b10;
        wait_accept("acc_err", 20);
        REQ_VALID = 2'b00;
        wait_drain("drain_err", 20);
        check_eq("err_flag", 32'(last_flags[FLAG_ERR]), 32'd1);
        check_eq("err_res", 32'(last_res), 32'd0);
        check_eq("err_id", 32'(last_id), 32'd1);

        // Reset while in ISSUE: operation discarded, no response
        set_req(0, 1'b1, CMD_ADD, 8'h01, 8'h02, 1'b0, 2'b11);
        REQ_VALID = 2'b01;
        wait_accept("acc_rst", 20);
        REQ_VALID = 2'b00;
        n_rsp0 = n_rsp;
        RST = 1'b1;
        tick();
        check_eq("rst_issue_valid", 32'(RSP_VALID), 32'd0);
        check_eq("rst_issue_ce", 32'(ALU_CE), 32'd0);
        RST = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("rst_no_rsp", 32'(RSP_VALID), 32'd0);
        end
        check_eq("rst_rsp_count", 32'(n_rsp), 32'(n_rsp0));
        set_req(1, 1'b1, CMD_ADD, 8'h07, 8'h08, 1'b0, 2'b11);
        REQ_VALID = 2'b10;
        wait_accept("acc_post_rst", 20);
        REQ_VALID = 2'b00;
        wait_drain("drain_post_rst", 20);
        check_eq("post_rst_res", 32'(last_res), 32'd15);
        check_eq("post_rst_id", 32'(last_id), 32'd1);

`ifdef ALU_SCHED_STATS_EN
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_eq("stat_rst_grant", 32'(STAT_GRANT_CNT), 32'd0);
        set_req(0, 1'b1, CMD_ADD, 8'h05, 8'h06, 1'b0, 2'b11);
        REQ_VALID = 2'b01;
        for (int k = 0; k < 3; k++) wait_accept("acc_stat0", 20);
        REQ_VALID = 2'b00;
        wait_drain("drain_stat0", 20);
        set_req(1, 1'b1, CMD_ADD, 8'h05, 8'h06, 1'b0, 2'b00);
        REQ_VALID = 2'b10;
        wait_accept("acc_stat1", 20);
        REQ_VALID = 2'b00;
        wait_drain("drain_stat1", 20);
        check_eq("stat_grant", 32'(STAT_GRANT_CNT), {16'd1, 16'd3});
        check_eq("stat_err", 32'(STAT_ERR_CNT), 32'd1);
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
